// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Shared encodings, FSM states and MMIO defaults for mem_access_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SRAM   = 2'd1,
        ST_TXWAIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] UART_DATA_ADDR_DEF = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR_DEF = 32'hBFD0_03FC;

    // Size 2'b11 falls into the word case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = addr_lo[0];
            default: r = (addr_lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module   : mem_lane_align
//  Brief    : Little-endian store lane steering and load lane extract/extend.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [31:0] i_ld_rdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_signed,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_ld_byte = i_ld_rdata[{i_ld_addr_lo, 3'b000} +: 8];
    assign w_ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = {{16{i_ld_signed & w_ld_half[15]}}, w_ld_half};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : MEM-stage load/store unit for external SRAM and UART MMIO registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned WAIT_CYCLES    = 1,
    parameter logic [31:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_start,
    input  logic              uart_tx_busy,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_clear
);

    localparam int unsigned CNT_W = 3;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [1:0]         r_addr_lo;
    logic [7:0]         r_wdata_lo;

    logic               w_misaligned;
    logic               w_is_stat;
    logic               w_is_data;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_wdata;
    logic [31:0]        w_ld_data;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_is_stat    = (req_addr == UART_STAT_ADDR);
    assign w_is_data    = (req_addr == UART_DATA_ADDR);

    // Store lanes come from the live request; the load path uses the held request.
    mem_lane_align u_lane_align (
        .i_st_size    (req_size),
        .i_st_addr_lo (req_addr[1:0]),
        .i_st_wdata   (req_wdata),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_rdata   (sram_rdata),
        .i_ld_size    (r_size),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_signed  (r_signed),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_addr_lo     <= 2'b00;
            r_wdata_lo    <= 8'h00;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            sram_ce       <= 1'b0;
            sram_we       <= 1'b0;
            sram_be       <= 4'b0000;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            uart_tx_data  <= 8'h00;
            uart_tx_start <= 1'b0;
            uart_rx_clear <= 1'b0;
        end else begin
            uart_tx_start <= 1'b0;
            uart_rx_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_addr_lo  <= req_addr[1:0];
                        r_wdata_lo <= req_wdata[7:0];
                        if (w_misaligned) begin
                            r_state    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (w_is_stat) begin
                            r_state    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= req_we ? 32'h0 : {30'b0, uart_rx_valid, ~uart_tx_busy};
                        end else if (w_is_data && !req_we) begin
                            r_state       <= ST_DONE;
                            resp_valid    <= 1'b1;
                            resp_rdata    <= {24'b0, uart_rx_data};
                            uart_rx_clear <= 1'b1;
                        end else if (w_is_data) begin
                            r_state <= ST_TXWAIT;
                        end else begin
                            r_state    <= ST_SRAM;
                            r_cnt      <= CNT_W'(WAIT_CYCLES - 1);
                            sram_ce    <= 1'b1;
                            sram_we    <= req_we;
                            sram_be    <= w_st_be;
                            sram_addr  <= req_addr[ADDR_W+1:2];
                            sram_wdata <= w_st_wdata;
                        end
                    end
                end
                ST_SRAM: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= r_we ? 32'h0 : w_ld_data;
                        sram_ce    <= 1'b0;
                        sram_we    <= 1'b0;
                        sram_be    <= 4'b0000;
                        sram_addr  <= '0;
                        sram_wdata <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_TXWAIT: begin
                    if (!uart_tx_busy) begin
                        r_state       <= ST_DONE;
                        uart_tx_start <= 1'b1;
                        uart_tx_data  <= r_wdata_lo;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= '0;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    req_ready    <= 1'b1;
                    resp_valid   <= 1'b0;
                    resp_err     <= 1'b0;
                    resp_rdata   <= '0;
                    uart_tx_data <= 8'h00;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
